opt4c_column_result_accumulator: RTL

- Hardware replacement for the column post-processing currently done in the bench.
- Sits directly after top_pe_column; receives one completed pass result per 2-bit digit index (bw).
- For each of N columns: fuses the two ACC_WIDTH partial sums, shifts the sum by 2*digit and accumulates across DIGITS passes into one row of C.
- Emits the row through a valid/ready output register, with saturation and overflow reporting and sequence-error detection.

---
 rtl/opt4c_column_result_accumulator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/opt4c_column_result_accumulator.sv
// rtl/opt4c_column_result_accumulator.sv - fuses per-column PE partial sums over digit passes into one output row
// Each row is accumulated over DIGITS passes and handed off through a single valid/ready output register.
module opt4c_column_result_accumulator #(
   parameter int N         = 32,
   parameter int ACC_WIDTH = 26,
   parameter int OUT_WIDTH = 32,
   parameter int DIGITS    = 4,
   parameter int ROW_W     = 5,
   parameter bit SAT       = 1'b1,
   localparam int DW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DW-1:0]            in_digit,
   input  logic [ROW_W-1:0]         in_row,
   input  logic [2*ACC_WIDTH*N-1:0] pe_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ROW_W-1:0]         out_row,
   output logic [OUT_WIDTH*N-1:0]   out_data,
   output logic [N-1:0]             out_ovf,
   output logic                     err,
   input  logic                     clr_err
);
   localparam int W_INT = ACC_WIDTH + 2 + 2*(DIGITS-1);
   localparam int XW    = ((W_INT > OUT_WIDTH) ? W_INT : OUT_WIDTH) + 1;
   localparam logic signed [XW-1:0] OMAX = (XW'(1) <<< (OUT_WIDTH-1)) - XW'(1);
   localparam logic signed [XW-1:0] OMIN = -(XW'(1) <<< (OUT_WIDTH-1));

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                  state_q;
   logic [DW-1:0]           cnt_q;
   logic [ROW_W-1:0]        row_tag_q;
   logic signed [W_INT-1:0] acc_q [N];
   logic                    out_valid_q;
   logic [ROW_W-1:0]        out_row_q;
   logic [OUT_WIDTH*N-1:0]  out_data_q;
   logic [N-1:0]            out_ovf_q;
   logic                    err_q;

   logic signed [W_INT-1:0] term_c [N];
   logic signed [W_INT-1:0] sum_c [N];
   logic [OUT_WIDTH*N-1:0]  out_data_d;
   logic [N-1:0]            out_ovf_d;
   logic                    accept, seq_ok, last_digit, load_out;

   assign in_ready   = !(out_valid_q && !out_ready);
   assign accept     = in_valid && in_ready;
   assign seq_ok     = (state_q == ACCUM) && (in_digit == cnt_q) && (in_row == row_tag_q);
   assign last_digit = (in_digit == DW'(DIGITS-1));
   // Only DIGITS==1 can finish a row from IDLE, since digit 0 is then also the last digit.
   assign load_out   = accept && last_digit && (seq_ok || (state_q == IDLE && in_digit == '0));

   always_comb begin
      logic [ACC_WIDTH-1:0]    p0, p1;
      logic signed [W_INT-1:0] fuse, fin;
      logic signed [XW-1:0]    fin_x;
      p0         = '0;
      p1         = '0;
      fuse       = '0;
      fin        = '0;
      fin_x      = '0;
      out_data_d = '0;
      out_ovf_d  = '0;
      term_c     = '{default: '0};
      sum_c      = '{default: '0};
      for (int c = 0; c < N; c++) begin
         p0        = pe_result[2*ACC_WIDTH*c +: ACC_WIDTH];
         p1        = pe_result[2*ACC_WIDTH*c+ACC_WIDTH +: ACC_WIDTH];
         fuse      = {{(W_INT-ACC_WIDTH){p0[ACC_WIDTH-1]}}, p0}
                   + {{(W_INT-ACC_WIDTH){p1[ACC_WIDTH-1]}}, p1};
         term_c[c] = fuse <<< {in_digit, 1'b0};
         sum_c[c]  = acc_q[c] + term_c[c];
         fin       = (state_q == IDLE) ? term_c[c] : sum_c[c];
         fin_x     = {{(XW-W_INT){fin[W_INT-1]}}, fin};
         out_ovf_d[c] = (fin_x > OMAX) || (fin_x < OMIN);
         if (SAT && fin_x > OMAX)
            out_data_d[OUT_WIDTH*c +: OUT_WIDTH] = OMAX[OUT_WIDTH-1:0];
         else if (SAT && fin_x < OMIN)
            out_data_d[OUT_WIDTH*c +: OUT_WIDTH] = OMIN[OUT_WIDTH-1:0];
         else
            out_data_d[OUT_WIDTH*c +: OUT_WIDTH] = fin_x[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         row_tag_q   <= '0;
         for (int c = 0; c < N; c++) acc_q[c] <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_data_q  <= '0;
         out_ovf_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
         if (clr_err) err_q <= 1'b0;
         if (load_out) begin
            out_valid_q <= 1'b1;
            out_row_q   <= in_row;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
         end
         if (accept) begin
            if (seq_ok && !last_digit) begin
               for (int c = 0; c < N; c++) acc_q[c] <= sum_c[c];
               cnt_q <= cnt_q + DW'(1);
            end else if (!seq_ok && in_digit == '0 && !last_digit) begin
               for (int c = 0; c < N; c++) acc_q[c] <= term_c[c];
               row_tag_q <= in_row;
               state_q   <= ACCUM;
               cnt_q     <= DW'(1);
            end else begin
               for (int c = 0; c < N; c++) acc_q[c] <= '0;
               state_q <= IDLE;
               cnt_q   <= '0;
            end
            // Set after the clear above so a same-cycle error beats clr_err.
            if (!seq_ok && (state_q == ACCUM || in_digit != '0)) err_q <= 1'b1;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_row   = out_row_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign err       = err_q;
endmodule
